// File: rtl/bp_be_stride_detector_pkg.sv
// Shared types and constants for the striding-load detector.
// The entry struct is declared through a macro so each module can size it
// from its own address, stride and loop-counter width parameters.

`define DECLARE_BP_BE_STRIDE_ENTRY_S(vaddr_width_mp, stride_width_mp, loop_width_mp) \
    typedef struct packed {                                                   \
        logic                        v;                                       \
        logic [vaddr_width_mp-1:0]   pc;                                      \
        logic [vaddr_width_mp-1:0]   last_addr;                               \
        logic [stride_width_mp-1:0]  stride;                                  \
        logic [1:0]                  conf;                                    \
        logic [loop_width_mp-1:0]    run;                                     \
        logic [loop_width_mp-1:0]    trip;                                    \
        logic                        issued;                                  \
    } bp_be_stride_entry_s

package bp_be_stride_detector_pkg;

    // Virtual address width of the default processor configuration.
    localparam int stride_vaddr_width_gp = 39;

    // Confidence counter saturates here.
    localparam logic [1:0] stride_conf_sat_lp = 2'b11;

endpackage

// File: rtl/bp_be_stride_detector_if.sv
// Descriptor handshake between the stride detector (master) and the
// prefetch generator (slave).

interface bp_be_stride_detector_if #(
    parameter int vaddr_width_p  = 39,
    parameter int stride_width_p = 8,
    parameter int loop_range_p   = 8
) ();
    logic                      v;
    logic                      ready_and;
    logic [vaddr_width_p-1:0]  pc;
    logic [vaddr_width_p-1:0]  eff_addr;
    logic [stride_width_p-1:0] stride;
    logic [loop_range_p-1:0]   loop_counter;

    modport master (
        output v, pc, eff_addr, stride, loop_counter,
        input  ready_and
    );

    modport slave (
        input  v, pc, eff_addr, stride, loop_counter,
        output ready_and
    );
endinterface

// File: rtl/bp_be_stride_entry.sv
// One stride-table entry: PC match, delta/stride compare, confidence, run
// and trip tracking, and the qualify signal for descriptor issue.

module bp_be_stride_entry
    import bp_be_stride_detector_pkg::*;
#(
    parameter int vaddr_width_p   = 39,
    parameter int stride_width_p  = 8,
    parameter int loop_range_p    = 8,
    parameter int conf_thresh_p   = 2,
    parameter int default_depth_p = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      clear_i,
    input  logic                      commit_v_i,
    input  logic [vaddr_width_p-1:0]  commit_pc_i,
    input  logic [vaddr_width_p-1:0]  commit_eff_addr_i,
    input  logic                      alloc_i,
    input  logic                      buf_free_i,
    output logic                      valid_o,
    output logic                      hit_o,
    output logic                      qualify_o,
    output logic [stride_width_p-1:0] stride_o,
    output logic [loop_range_p-1:0]   loop_counter_o
);

    `DECLARE_BP_BE_STRIDE_ENTRY_S(vaddr_width_p, stride_width_p, loop_range_p);

    bp_be_stride_entry_s entry_q, entry_d;

    logic [vaddr_width_p-1:0] delta;
    logic                     fits;
    logic                     stride_match;

    // Next-state update of the entry plus issue qualification on the updated values.
    always_comb begin
        delta        = commit_eff_addr_i - entry_q.last_addr;
        fits         = (delta == {{(vaddr_width_p-stride_width_p){delta[stride_width_p-1]}},
                                  delta[stride_width_p-1:0]}) && (|delta);
        stride_match = fits && (delta[stride_width_p-1:0] == entry_q.stride);
        hit_o        = entry_q.v && commit_v_i && !clear_i && (commit_pc_i == entry_q.pc);
        entry_d      = entry_q;
        qualify_o    = 1'b0;

        if (clear_i) begin
            entry_d.v = 1'b0;
        end else if (alloc_i) begin
            entry_d.v         = 1'b1;
            entry_d.pc        = commit_pc_i;
            entry_d.last_addr = commit_eff_addr_i;
            entry_d.stride    = '0;
            entry_d.conf      = '0;
            entry_d.run       = '0;
            entry_d.trip      = '0;
            entry_d.issued    = 1'b0;
        end else if (hit_o) begin
            entry_d.last_addr = commit_eff_addr_i;
            if (stride_match) begin
                if (entry_q.conf != stride_conf_sat_lp)
                    entry_d.conf = entry_q.conf + 2'd1;
                if (entry_q.run != '1)
                    entry_d.run = entry_q.run + 1'b1;
            end else begin
                if (entry_q.run != '0)
                    entry_d.trip = entry_q.run;
                entry_d.stride = fits ? delta[stride_width_p-1:0] : '0;
                entry_d.conf   = '0;
                entry_d.run    = '0;
                entry_d.issued = 1'b0;
            end
            qualify_o = (entry_d.conf >= 2'(conf_thresh_p)) && (entry_d.stride != '0)
                        && !entry_d.issued;
            // Only mark issued when the descriptor actually lands in the buffer,
            // so a blocked entry retries on its next matching commit.
            if (qualify_o && buf_free_i)
                entry_d.issued = 1'b1;
        end
    end

    // Predicted remaining iterations: trip history minus progress, else default depth.
    always_comb begin
        if (entry_q.trip > entry_d.run)
            loop_counter_o = entry_q.trip - entry_d.run;
        else
            loop_counter_o = loop_range_p'(default_depth_p);
    end

    assign valid_o  = entry_q.v;
    assign stride_o = entry_d.stride;

    // Entry register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            entry_q <= '0;
        else
            entry_q <= entry_d;
    end

endmodule

// File: rtl/bp_be_stride_detector.sv
// Striding-load detector: watches committed loads, tracks per-PC strides in a
// small fully associative table and emits one descriptor per stable stride.
// Optional feature: define BP_BE_STRIDE_DETECTOR_PERF_EN to add saturating
// issue_count_o / drop_count_o performance counters.

module bp_be_stride_detector
    import bp_be_stride_detector_pkg::*;
#(
    parameter int vaddr_width_p   = stride_vaddr_width_gp,
    parameter int entries_p       = 4,
    parameter int loop_range_p    = 8,
    parameter int stride_width_p  = 8,
    parameter int conf_thresh_p   = 2,
    parameter int default_depth_p = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     commit_v_i,
    input  logic [vaddr_width_p-1:0] commit_pc_i,
    input  logic [vaddr_width_p-1:0] commit_eff_addr_i,
    bp_be_stride_detector_if.master  desc_if
`ifdef BP_BE_STRIDE_DETECTOR_PERF_EN
    ,
    output logic [31:0]              issue_count_o,
    output logic [31:0]              drop_count_o
`endif
);

    localparam int idx_w_lp = $clog2(entries_p);

    logic [entries_p-1:0]      valid, hit, qualify, alloc;
    logic [stride_width_p-1:0] ent_stride [entries_p];
    logic [loop_range_p-1:0]   ent_loop   [entries_p];

    logic [idx_w_lp-1:0]       victim_q, victim_d, alloc_idx;
    logic                      found_free, miss;
    logic                      buf_free, issue, any_qualify;
    logic [stride_width_p-1:0] sel_stride;
    logic [loop_range_p-1:0]   sel_loop;

    logic                      v_q, v_d;
    logic [vaddr_width_p-1:0]  pc_q, addr_q;
    logic [stride_width_p-1:0] stride_q;
    logic [loop_range_p-1:0]   loop_q;

    for (genvar i = 0; i < entries_p; i++) begin : g_entry
        bp_be_stride_entry #(
            .vaddr_width_p   (vaddr_width_p),
            .stride_width_p  (stride_width_p),
            .loop_range_p    (loop_range_p),
            .conf_thresh_p   (conf_thresh_p),
            .default_depth_p (default_depth_p)
        ) u_entry (
            .clk_i             (clk_i),
            .reset_i           (reset_i),
            .clear_i           (clear_i),
            .commit_v_i        (commit_v_i),
            .commit_pc_i       (commit_pc_i),
            .commit_eff_addr_i (commit_eff_addr_i),
            .alloc_i           (alloc[i]),
            .buf_free_i        (buf_free),
            .valid_o           (valid[i]),
            .hit_o             (hit[i]),
            .qualify_o         (qualify[i]),
            .stride_o          (ent_stride[i]),
            .loop_counter_o    (ent_loop[i])
        );
    end

    // Miss allocation: lowest free entry first, otherwise round-robin victim.
    always_comb begin
        alloc      = '0;
        found_free = 1'b0;
        alloc_idx  = victim_q;
        victim_d   = victim_q;
        miss       = commit_v_i && !clear_i && !(|hit);
        for (int i = 0; i < entries_p; i++) begin
            if (!found_free && !valid[i]) begin
                found_free = 1'b1;
                alloc_idx  = idx_w_lp'(i);
            end
        end
        if (miss) begin
            alloc[alloc_idx] = 1'b1;
            if (!found_free)
                victim_d = victim_q + 1'b1;
        end
        if (clear_i)
            victim_d = '0;
    end

    // Select the (at most one) qualifying entry and decide whether it can issue.
    always_comb begin
        sel_stride = '0;
        sel_loop   = '0;
        for (int i = 0; i < entries_p; i++) begin
            if (qualify[i]) begin
                sel_stride = ent_stride[i];
                sel_loop   = ent_loop[i];
            end
        end
        any_qualify = |qualify;
        buf_free    = !v_q || desc_if.ready_and;
        issue       = any_qualify && buf_free;
    end

    // Output buffer valid: clear wins, reload beats drain.
    always_comb begin
        v_d = v_q;
        if (clear_i)
            v_d = 1'b0;
        else if (issue)
            v_d = 1'b1;
        else if (desc_if.ready_and)
            v_d = 1'b0;
    end

    // Output buffer and victim pointer registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_q      <= 1'b0;
            pc_q     <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            loop_q   <= '0;
            victim_q <= '0;
        end else begin
            v_q      <= v_d;
            victim_q <= victim_d;
            if (issue && !clear_i) begin
                pc_q     <= commit_pc_i;
                addr_q   <= commit_eff_addr_i;
                stride_q <= sel_stride;
                loop_q   <= sel_loop;
            end
        end
    end

    assign desc_if.v            = v_q;
    assign desc_if.pc           = pc_q;
    assign desc_if.eff_addr     = addr_q;
    assign desc_if.stride       = stride_q;
    assign desc_if.loop_counter = loop_q;

`ifdef BP_BE_STRIDE_DETECTOR_PERF_EN
    logic [31:0] issue_cnt_q, drop_cnt_q;

    // Saturating accepted-descriptor and blocked-issue counters.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            issue_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else if (clear_i) begin
            issue_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (v_q && desc_if.ready_and && (issue_cnt_q != '1))
                issue_cnt_q <= issue_cnt_q + 32'd1;
            if (any_qualify && !buf_free && (drop_cnt_q != '1))
                drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    assign issue_count_o = issue_cnt_q;
    assign drop_count_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_bp_be_stride_detector.sv
// Directed bench for the striding-load detector.

module tb_bp_be_stride_detector;

    localparam int VW = 39;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          clear_i;
    logic          commit_v_i;
    logic [VW-1:0] commit_pc_i;
    logic [VW-1:0] commit_eff_addr_i;

    int n_checks = 0;
    int n_errors = 0;

    bp_be_stride_detector_if #(.vaddr_width_p(VW), .stride_width_p(8), .loop_range_p(8)) desc_if ();

`ifdef BP_BE_STRIDE_DETECTOR_PERF_EN
    logic [31:0] issue_count, drop_count;
`endif

    bp_be_stride_detector #(
        .vaddr_width_p   (VW),
        .entries_p       (4),
        .loop_range_p    (8),
        .stride_width_p  (8),
        .conf_thresh_p   (2),
        .default_depth_p (4)
    ) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .clear_i           (clear_i),
        .commit_v_i        (commit_v_i),
        .commit_pc_i       (commit_pc_i),
        .commit_eff_addr_i (commit_eff_addr_i),
        .desc_if           (desc_if.master)
`ifdef BP_BE_STRIDE_DETECTOR_PERF_EN
        ,
        .issue_count_o     (issue_count),
        .drop_count_o      (drop_count)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of commit inputs (called at a negedge); returns at the
    // following negedge so outputs reflect the intervening posedge.
    task automatic step(input logic v, input logic [63:0] pc, input logic [63:0] addr);
        commit_v_i        = v;
        commit_pc_i       = pc[VW-1:0];
        commit_eff_addr_i = addr[VW-1:0];
        @(negedge clk_i);
        commit_v_i        = 1'b0;
    endtask

    task automatic check_desc(input string tag, input logic [63:0] pc, input logic [63:0] addr,
                              input logic [63:0] stride, input logic [63:0] loop_cnt);
        check({tag, "_v"},      64'(desc_if.v), 64'h1);
        check({tag, "_pc"},     64'(desc_if.pc), pc);
        check({tag, "_addr"},   64'(desc_if.eff_addr), addr);
        check({tag, "_stride"}, 64'(desc_if.stride), stride);
        check({tag, "_loop"},   64'(desc_if.loop_counter), loop_cnt);
    endtask

    logic seen_v;

    initial begin
        reset_i           = 1'b1;
        clear_i           = 1'b0;
        commit_v_i        = 1'b0;
        commit_pc_i       = '0;
        commit_eff_addr_i = '0;
        desc_if.ready_and = 1'b1;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;

        check("rst_v",      64'(desc_if.v), 64'h0);
        check("rst_pc",     64'(desc_if.pc), 64'h0);
        check("rst_addr",   64'(desc_if.eff_addr), 64'h0);
        check("rst_stride", 64'(desc_if.stride), 64'h0);
        check("rst_loop",   64'(desc_if.loop_counter), 64'h0);

        // Steady stride of 8.
        step(1'b1, 64'h80, 64'h1000);
        check("steady_v1", 64'(desc_if.v), 64'h0);
        step(1'b1, 64'h80, 64'h1008);
        step(1'b1, 64'h80, 64'h1010);
        check("steady_v3", 64'(desc_if.v), 64'h0);
        step(1'b1, 64'h80, 64'h1018);
        check_desc("steady", 64'h80, 64'h1018, 64'h08, 64'h4);
        step(1'b1, 64'h80, 64'h1020);
        check("steady_v5", 64'(desc_if.v), 64'h0);

        // Trip prediction: run of 8, break, then re-qualify.
        for (int k = 0; k < 10; k++) step(1'b1, 64'h90, 64'h1000 + 64'(8*k));
        step(1'b1, 64'h90, 64'h5000);
        check("trip_break_v", 64'(desc_if.v), 64'h0);
        step(1'b1, 64'h90, 64'h5008);
        step(1'b1, 64'h90, 64'h5010);
        step(1'b1, 64'h90, 64'h5018);
        check_desc("trip", 64'h90, 64'h5018, 64'h08, 64'h6);

        // Negative stride.
        step(1'b1, 64'hA0, 64'h2000);
        step(1'b1, 64'hA0, 64'h1FF0);
        step(1'b1, 64'hA0, 64'h1FE0);
        step(1'b1, 64'hA0, 64'h1FD0);
        check_desc("neg", 64'hA0, 64'h1FD0, 64'hF0, 64'h4);

        // Stride too wide for 8 bits never issues.
        seen_v = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 64'hB0, 64'h8000 + 64'(32'h400 * k));
            if (k > 0 && desc_if.v) seen_v = 1'b1;
        end
        check("nofit_never_v", 64'(seen_v), 64'h0);

        // Backpressure with two qualifying PCs.
        clear_i = 1'b1;
        step(1'b0, 64'h0, 64'h0);
        clear_i = 1'b0;
        desc_if.ready_and = 1'b0;
        for (int k = 0; k < 4; k++) step(1'b1, 64'hC0, 64'h100 + 64'(8*k));
        check_desc("bp_first", 64'hC0, 64'h118, 64'h08, 64'h4);
        for (int k = 0; k < 4; k++) step(1'b1, 64'hD0, 64'h200 + 64'(8*k));
        check_desc("bp_held", 64'hC0, 64'h118, 64'h08, 64'h4);
`ifdef BP_BE_STRIDE_DETECTOR_PERF_EN
        check("bp_drop_cnt", 64'(drop_count), 64'h1);
`endif
        desc_if.ready_and = 1'b1;
        step(1'b0, 64'h0, 64'h0);
        check("bp_drain_v", 64'(desc_if.v), 64'h0);
        step(1'b1, 64'hD0, 64'h220);
        check_desc("bp_second", 64'hD0, 64'h220, 64'h08, 64'h4);
`ifdef BP_BE_STRIDE_DETECTOR_PERF_EN
        check("bp_issue_cnt", 64'(issue_count), 64'h1);
`endif
        step(1'b0, 64'h0, 64'h0);

        // Clear together with a qualifying commit.
        clear_i = 1'b1;
        step(1'b0, 64'h0, 64'h0);
        clear_i = 1'b0;
`ifdef BP_BE_STRIDE_DETECTOR_PERF_EN
        check("clr_issue_cnt", 64'(issue_count), 64'h0);
`endif
        step(1'b1, 64'h700, 64'h7000);
        step(1'b1, 64'h700, 64'h7008);
        step(1'b1, 64'h700, 64'h7010);
        clear_i = 1'b1;
        step(1'b1, 64'h700, 64'h7018);
        clear_i = 1'b0;
        check("clr_same_cycle_v", 64'(desc_if.v), 64'h0);
        step(1'b1, 64'h700, 64'h7018);
        check("clr_table_empty_v", 64'(desc_if.v), 64'h0);

        // Replacement: five PCs into four entries.
        clear_i = 1'b1;
        step(1'b0, 64'h0, 64'h0);
        clear_i = 1'b0;
        step(1'b1, 64'h100, 64'h1000);
        step(1'b1, 64'h100, 64'h1008);
        step(1'b1, 64'h200, 64'h3000);
        step(1'b1, 64'h200, 64'h3008);
        step(1'b1, 64'h300, 64'h4000);
        step(1'b1, 64'h400, 64'h4100);
        step(1'b1, 64'h500, 64'h4200);
        step(1'b1, 64'h100, 64'h1010);
        check("repl_a_miss_v", 64'(desc_if.v), 64'h0);
        step(1'b1, 64'h100, 64'h1018);
        check("repl_a_evicted_v", 64'(desc_if.v), 64'h0);
        step(1'b1, 64'h100, 64'h1020);
        step(1'b1, 64'h100, 64'h1028);
        check_desc("repl_a", 64'h100, 64'h1028, 64'h08, 64'h4);
        step(1'b1, 64'h200, 64'h3010);
        check("repl_b_miss_v", 64'(desc_if.v), 64'h0);
        step(1'b1, 64'h200, 64'h3018);
        check("repl_b_evicted_v", 64'(desc_if.v), 64'h0);

        // Asynchronous reset while a descriptor is held.
        desc_if.ready_and = 1'b0;
        for (int k = 0; k < 4; k++) step(1'b1, 64'h600, 64'h9000 + 64'(8*k));
        check("arst_pre_v", 64'(desc_if.v), 64'h1);
        #1 reset_i = 1'b1;
        #1;
        check("arst_v",    64'(desc_if.v), 64'h0);
        check("arst_pc",   64'(desc_if.pc), 64'h0);
        check("arst_loop", 64'(desc_if.loop_counter), 64'h0);
        @(negedge clk_i);
        reset_i = 1'b0;
        desc_if.ready_and = 1'b1;
        step(1'b0, 64'h0, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
